// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid tracking, stall/flush control and an input skid FIFO
// that holds words arriving while the stage is stalled and replays them in order.
module pipe_stage_skid #(
   parameter int unsigned PC_W       = 32,
   parameter int unsigned INST_W     = 32,
   parameter int unsigned STALL_W    = 6,
   parameter int unsigned STAGE      = 1,
   parameter int unsigned SKID_DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [STALL_W-1:0]            stall,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [PC_W-1:0]               in_pc,
   input  logic [INST_W-1:0]             in_inst,
   output logic                          out_valid,
   output logic [PC_W-1:0]               out_pc,
   output logic [INST_W-1:0]             out_inst,
   output logic [$clog2(SKID_DEPTH):0]   skid_count
);

   localparam int unsigned PTR_W = $clog2(SKID_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } word_t;

   word_t             mem_q [SKID_DEPTH];
   word_t             mem_d [SKID_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   word_t             out_q, out_d;
   logic              out_valid_q, out_valid_d;

   logic  up, dn;
   logic  accept, fifo_empty, push, pop;
   word_t in_word, head;
   logic  unused_stall;

   assign up = stall[STAGE];
   assign dn = stall[STAGE+1];
   // Only two bits of the global stall bus matter to this stage.
   assign unused_stall = ^stall;

   assign in_ready   = rst & (cnt_q < CNT_W'(SKID_DEPTH));
   assign accept     = in_valid & in_ready & ~flush;
   assign fifo_empty = (cnt_q == '0);
   assign in_word    = '{pc: in_pc, inst: in_inst};
   assign head       = mem_q[rd_ptr_q];

   // Next-state: output register selection plus FIFO push/pop bookkeeping.
   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      push        = 1'b0;
      pop         = 1'b0;

      if (flush) begin
         out_d       = '0;
         out_valid_d = 1'b0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         cnt_d       = '0;
      end else begin
         if (!up) begin
            if (!fifo_empty) begin
               out_d       = head;
               out_valid_d = 1'b1;
               pop         = 1'b1;
               push        = accept;
            end else if (accept) begin
               out_d       = in_word;
               out_valid_d = 1'b1;
            end else begin
               out_d       = '0;
               out_valid_d = 1'b0;
            end
         end else begin
            if (!dn) begin
               out_d       = '0;
               out_valid_d = 1'b0;
            end
            push = accept;
         end

         if (push) begin
            mem_d[wr_ptr_q] = in_word;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_pc     = out_q.pc;
   assign out_inst   = out_q.inst;
   assign skid_count = cnt_q;

endmodule
